hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline control block for the 5-stage 16-bit core.
- Produces the write-enable and flush controls consumed by the pipeline registers: the id_ex write enable (hzrd, 1 = capture) and id_ex clear (branch), plus the if_id, PC and ex_mem enables.
- Looks at decode-stage register reads, the id_ex outputs (execute stage), EX branch resolution and the data-memory busy flag.
- Sequences load-use bubbles, branch flushes, memory freezes and halt drain.

Parameters:
- STALL_CNT_W, 16, width of the saturating stall-cycle counter.
- DRAIN_CYCLES, 3, cycles after HLT leaves EX before halt_o asserts (covers the EX, MEM and WB drain).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- id_rs_i  in  4  register-file read address 1 of the instruction in ID.
- id_rt_i  in  4  register-file read address 2 of the instruction in ID.
- id_rs_vld_i  in  1  ID instruction actually reads id_rs_i.
- id_rt_vld_i  in  1  ID instruction actually reads id_rt_i.
- ex_op_i  in  4  opcode in EX (id_ex op output).
- ex_rd_i  in  4  destination register in EX (id_ex rd output).
- br_taken_i  in  1  branch in EX resolved taken; PC target valid this cycle.
- dmem_busy_i  in  1  data memory has not completed the MEM-stage access.
- pc_we_o  out  1  PC update enable.
- if_id_we_o  out  1  if_id capture enable.
- id_ex_we_o  out  1  id_ex capture enable; drives hzrd.
- ex_mem_we_o  out  1  ex_mem and mem_wb capture enable.
- flush_if_id_o  out  1  clear if_id on the next edge.
- flush_id_ex_o  out  1  clear id_ex on the next edge; drives branch.
- halt_o  out  1  registered, sticky; core halted.
- stall_cnt_o  out  STALL_CNT_W  registered, saturating count of cycles with pc_we_o = 0 outside HALTED.

Behaviour:
- Opcodes: LW = 4'b1000, HLT = 4'b1111.
- States: RUN, MEM_WAIT, DRAIN, HALTED. A 2-bit drain counter is used in DRAIN.
- Reset (rst = 1 at an edge):
  - state <= RUN, drain counter <= 0, halt_o <= 0, stall_cnt_o <= 0.
  - While rst is high, outputs are all enables = 0, flush_if_id_o = 1, flush_id_ex_o = 1.
  - Reset mid-operation, in any state, returns to RUN on the same edge.
- Load-use condition (lu): ex_op_i == LW and ex_rd_i != 0, and either (id_rs_vld_i and id_rs_i == ex_rd_i) or (id_rt_vld_i and id_rt_i == ex_rd_i). A reference to R0 never stalls.
- Combinational outputs in RUN, first match wins:
  1. dmem_busy_i = 1: all four enables 0, both flushes 0 (full freeze). Next state is MEM_WAIT.
  2. br_taken_i = 1: pc_we_o = 1, if_id_we_o = 1, id_ex_we_o = 1, ex_mem_we_o = 1, flush_if_id_o = 1, flush_id_ex_o = 1. This overrides lu, because the ID instruction is wrong-path.
  3. ex_op_i == HLT: pc_we_o = 0, if_id_we_o = 0, flush_id_ex_o = 1, ex_mem_we_o = 1. Next state is DRAIN, drain counter <= 1.
  4. lu: pc_we_o = 0, if_id_we_o = 0, flush_id_ex_o = 1 (one bubble), ex_mem_we_o = 1. The bubble is exactly one cycle, since LW advances to MEM.
  5. Otherwise: all enables 1, flushes 0.
- MEM_WAIT:
  - Outputs are held exactly as in rule 1 while dmem_busy_i = 1.
  - When dmem_busy_i falls, the RUN rules apply combinationally in that same cycle and the next state is RUN (zero-cycle release).
  - br_taken_i held during the freeze is not acted on until release. The EX instruction is frozen, so br_taken_i is re-presented.
- DRAIN:
  - pc_we_o = 0, if_id_we_o = 0, flush_id_ex_o = 1.
  - ex_mem_we_o = !dmem_busy_i. The drain counter increments only when dmem_busy_i = 0.
  - br_taken_i is ignored, because HLT is already past EX.
  - When the counter reaches DRAIN_CYCLES with dmem_busy_i = 0: the next state is HALTED and halt_o <= 1 at that edge.
- HALTED: all enables 0, flush_if_id_o = 1, flush_id_ex_o = 1. halt_o stays 1 until rst.
- Stall counter:
  - Increments on every edge where state != HALTED, rst = 0 and pc_we_o = 0.
  - Saturates at all-ones with no wrap.

Test Plan:
- Load-use: LW R3 in EX (ex_rd_i = 3), ID reads rs = 3 with id_rs_vld_i = 1 -> exactly 1 cycle of pc_we_o = 0, if_id_we_o = 0, flush_id_ex_o = 1; stall_cnt_o = 1; the next cycle, with ex_op_i = bubble, all enables are 1.
- R0 / valid masking:
  - ex_rd_i = 0 with a matching rs -> no stall.
  - ex_rd_i = 5 and id_rt_i = 5 with id_rt_vld_i = 0 -> no stall.
- Branch vs load-use: br_taken_i = 1 and lu true in the same cycle -> flush_if_id_o = 1, flush_id_ex_o = 1, pc_we_o = 1, stall_cnt_o unchanged.
- Memory freeze: dmem_busy_i high for 4 cycles with br_taken_i = 1 -> all enables 0 and no flush for those 4 cycles; on the release cycle the branch flush fires once; stall_cnt_o += 4.
- Halt drain: HLT in EX with dmem_busy_i = 0 -> halt_o = 1 after the edge ending the 3rd drain cycle; with dmem_busy_i = 1 for 2 drain cycles, halt_o arrives 2 cycles later; halt_o is sticky, and rst clears it to 0.
- Saturation and reset: with STALL_CNT_W = 4, hold dmem_busy_i for 20 cycles -> stall_cnt_o = 15; assert rst mid-DRAIN -> state RUN, stall_cnt_o = 0, halt_o = 0, both flushes 1 while rst is high.

Source files
------------

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard controller: load-use bubbles, branch flush, memory freeze, halt drain
module hazard_ctrl #(
   parameter int STALL_CNT_W  = 16,
   parameter int DRAIN_CYCLES = 3
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [3:0]             id_rs_i,
   input  logic [3:0]             id_rt_i,
   input  logic                   id_rs_vld_i,
   input  logic                   id_rt_vld_i,
   input  logic [3:0]             ex_op_i,
   input  logic [3:0]             ex_rd_i,
   input  logic                   br_taken_i,
   input  logic                   dmem_busy_i,
   output logic                   pc_we_o,
   output logic                   if_id_we_o,
   output logic                   id_ex_we_o,
   output logic                   ex_mem_we_o,
   output logic                   flush_if_id_o,
   output logic                   flush_id_ex_o,
   output logic                   halt_o,
   output logic [STALL_CNT_W-1:0] stall_cnt_o
);

   localparam logic [3:0] OP_LW  = 4'b1000;
   localparam logic [3:0] OP_HLT = 4'b1111;
   localparam logic [1:0] DRAIN_LAST = DRAIN_CYCLES[1:0];
   localparam logic [STALL_CNT_W-1:0] CNT_ONE = {{(STALL_CNT_W-1){1'b0}}, 1'b1};
   localparam logic [STALL_CNT_W-1:0] CNT_MAX = {STALL_CNT_W{1'b1}};

   typedef enum logic [1:0] {S_RUN, S_MEM_WAIT, S_DRAIN, S_HALTED} state_t;

   state_t                 state_q, state_d;
   logic [1:0]             drain_q, drain_d;
   logic                   halt_q, halt_d;
   logic [STALL_CNT_W-1:0] stall_q, stall_d;
   logic                   lu;
   logic                   ex_hlt;

   // Load-use: the LW in EX writes a register the ID instruction really reads; R0 never hazards
   assign lu = (ex_op_i == OP_LW) && (ex_rd_i != 4'd0) &&
               ((id_rs_vld_i && (id_rs_i == ex_rd_i)) || (id_rt_vld_i && (id_rt_i == ex_rd_i)));
   assign ex_hlt = (ex_op_i == OP_HLT);

   // State, drain counter, halt flag and stall counter registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_RUN;
         drain_q <= 2'd0;
         halt_q  <= 1'b0;
         stall_q <= '0;
      end else begin
         state_q <= state_d;
         drain_q <= drain_d;
         halt_q  <= halt_d;
         stall_q <= stall_d;
      end
   end

   // Next-state logic; MEM_WAIT re-evaluates the RUN rules the moment the memory releases
   always_comb begin
      state_d = state_q;
      drain_d = drain_q;
      halt_d  = halt_q;
      case (state_q)
         S_RUN, S_MEM_WAIT: begin
            if (dmem_busy_i) begin
               state_d = S_MEM_WAIT;
            end else if (br_taken_i) begin
               state_d = S_RUN;
            end else if (ex_hlt) begin
               state_d = S_DRAIN;
               drain_d = 2'd1;
            end else begin
               state_d = S_RUN;
            end
         end
         S_DRAIN: begin
            if (!dmem_busy_i) begin
               if (drain_q == DRAIN_LAST) begin
                  state_d = S_HALTED;
                  halt_d  = 1'b1;
               end else begin
                  drain_d = drain_q + 2'd1;
               end
            end
         end
         default: state_d = S_HALTED;
      endcase
   end

   // Pipeline enables and flushes; reset forces a cleared, frozen pipe
   always_comb begin
      pc_we_o       = 1'b1;
      if_id_we_o    = 1'b1;
      id_ex_we_o    = 1'b1;
      ex_mem_we_o   = 1'b1;
      flush_if_id_o = 1'b0;
      flush_id_ex_o = 1'b0;
      if (rst || (state_q == S_HALTED)) begin
         pc_we_o       = 1'b0;
         if_id_we_o    = 1'b0;
         id_ex_we_o    = 1'b0;
         ex_mem_we_o   = 1'b0;
         flush_if_id_o = 1'b1;
         flush_id_ex_o = 1'b1;
      end else if (state_q == S_DRAIN) begin
         pc_we_o       = 1'b0;
         if_id_we_o    = 1'b0;
         flush_id_ex_o = 1'b1;
         ex_mem_we_o   = !dmem_busy_i;
      end else if (dmem_busy_i) begin
         pc_we_o       = 1'b0;
         if_id_we_o    = 1'b0;
         id_ex_we_o    = 1'b0;
         ex_mem_we_o   = 1'b0;
      end else if (br_taken_i) begin
         flush_if_id_o = 1'b1;
         flush_id_ex_o = 1'b1;
      end else if (ex_hlt || lu) begin
         pc_we_o       = 1'b0;
         if_id_we_o    = 1'b0;
         flush_id_ex_o = 1'b1;
      end
   end

   // Saturating count of cycles the PC is held, excluding the halted state
   always_comb begin
      stall_d = stall_q;
      if ((state_q != S_HALTED) && !pc_we_o && (stall_q != CNT_MAX)) begin
         stall_d = stall_q + CNT_ONE;
      end
   end

   assign halt_o      = halt_q;
   assign stall_cnt_o = stall_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed self-checking bench for hazard_ctrl
module tb_hazard_ctrl;

   localparam logic [3:0] LW  = 4'b1000;
   localparam logic [3:0] HLT = 4'b1111;

   logic clk = 1'b0;
   logic rst;
   logic [3:0] id_rs, id_rt, ex_op, ex_rd;
   logic id_rs_vld, id_rt_vld, br_taken, dmem_busy;

   logic pc_we, if_id_we, id_ex_we, ex_mem_we, f_ifid, f_idex, halt;
   logic [15:0] stall_cnt;
   logic s_pc_we, s_if_id_we, s_id_ex_we, s_ex_mem_we, s_f_ifid, s_f_idex, s_halt;
   logic [3:0] s_stall_cnt;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   hazard_ctrl #(.STALL_CNT_W(16), .DRAIN_CYCLES(3)) dut (
      .clk(clk), .rst(rst), .id_rs_i(id_rs), .id_rt_i(id_rt),
      .id_rs_vld_i(id_rs_vld), .id_rt_vld_i(id_rt_vld), .ex_op_i(ex_op), .ex_rd_i(ex_rd),
      .br_taken_i(br_taken), .dmem_busy_i(dmem_busy),
      .pc_we_o(pc_we), .if_id_we_o(if_id_we), .id_ex_we_o(id_ex_we), .ex_mem_we_o(ex_mem_we),
      .flush_if_id_o(f_ifid), .flush_id_ex_o(f_idex), .halt_o(halt), .stall_cnt_o(stall_cnt)
   );

   hazard_ctrl #(.STALL_CNT_W(4), .DRAIN_CYCLES(3)) dut_sat (
      .clk(clk), .rst(rst), .id_rs_i(id_rs), .id_rt_i(id_rt),
      .id_rs_vld_i(id_rs_vld), .id_rt_vld_i(id_rt_vld), .ex_op_i(ex_op), .ex_rd_i(ex_rd),
      .br_taken_i(br_taken), .dmem_busy_i(dmem_busy),
      .pc_we_o(s_pc_we), .if_id_we_o(s_if_id_we), .id_ex_we_o(s_id_ex_we), .ex_mem_we_o(s_ex_mem_we),
      .flush_if_id_o(s_f_ifid), .flush_id_ex_o(s_f_idex), .halt_o(s_halt), .stall_cnt_o(s_stall_cnt)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      id_rs = 4'd0; id_rt = 4'd0; id_rs_vld = 1'b0; id_rt_vld = 1'b0;
      ex_op = 4'd0; ex_rd = 4'd0; br_taken = 1'b0; dmem_busy = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; idle(); #2;
      checks++; if ({pc_we, if_id_we, id_ex_we, ex_mem_we, f_ifid, f_idex} !== 6'b000011) begin
         failures++; $display("FAIL reset_outputs got=%b exp=000011", {pc_we, if_id_we, id_ex_we, ex_mem_we, f_ifid, f_idex}); end
      tick();
      checks++; if ({halt, stall_cnt} !== 17'd0) begin
         failures++; $display("FAIL reset_regs got halt=%b cnt=%0d exp halt=0 cnt=0", halt, stall_cnt); end
      rst = 1'b0; #2;
      checks++; if ({pc_we, if_id_we, id_ex_we, ex_mem_we, f_ifid, f_idex} !== 6'b111100) begin
         failures++; $display("FAIL run_idle got=%b exp=111100", {pc_we, if_id_we, id_ex_we, ex_mem_we, f_ifid, f_idex}); end
      tick();
      checks++; if (stall_cnt !== 16'd0) begin
         failures++; $display("FAIL idle_cnt got=%0d exp=0", stall_cnt); end
   endtask

   task automatic test_load_use();
      ex_op = LW; ex_rd = 4'd3; id_rs = 4'd3; id_rs_vld = 1'b1; #2;
      checks++; if ({pc_we, if_id_we, ex_mem_we, f_ifid, f_idex} !== 5'b00101) begin
         failures++; $display("FAIL lu_bubble got=%b exp=00101", {pc_we, if_id_we, ex_mem_we, f_ifid, f_idex}); end
      tick();
      checks++; if (stall_cnt !== 16'd1) begin
         failures++; $display("FAIL lu_cnt got=%0d exp=1", stall_cnt); end
      idle(); #2;
      checks++; if ({pc_we, if_id_we, id_ex_we, ex_mem_we, f_ifid, f_idex} !== 6'b111100) begin
         failures++; $display("FAIL lu_after got=%b exp=111100", {pc_we, if_id_we, id_ex_we, ex_mem_we, f_ifid, f_idex}); end
      tick();
   endtask

   task automatic test_masking();
      ex_op = LW; ex_rd = 4'd0; id_rs = 4'd0; id_rs_vld = 1'b1; #2;
      checks++; if (pc_we !== 1'b1) begin
         failures++; $display("FAIL r0_no_stall got pc_we=%b exp=1", pc_we); end
      ex_rd = 4'd5; id_rs = 4'd1; id_rt = 4'd5; id_rt_vld = 1'b0; #2;
      checks++; if (pc_we !== 1'b1) begin
         failures++; $display("FAIL rt_vld_mask got pc_we=%b exp=1", pc_we); end
      id_rt_vld = 1'b1; #2;
      checks++; if ({pc_we, f_idex} !== 2'b01) begin
         failures++; $display("FAIL rt_stall got=%b exp=01", {pc_we, f_idex}); end
      tick();
      checks++; if (stall_cnt !== 16'd2) begin
         failures++; $display("FAIL rt_cnt got=%0d exp=2", stall_cnt); end
      idle(); tick();
   endtask

   task automatic test_branch_vs_lu();
      ex_op = LW; ex_rd = 4'd3; id_rs = 4'd3; id_rs_vld = 1'b1; br_taken = 1'b1; #2;
      checks++; if ({pc_we, if_id_we, id_ex_we, ex_mem_we, f_ifid, f_idex} !== 6'b111111) begin
         failures++; $display("FAIL br_over_lu got=%b exp=111111", {pc_we, if_id_we, id_ex_we, ex_mem_we, f_ifid, f_idex}); end
      tick();
      checks++; if (stall_cnt !== 16'd2) begin
         failures++; $display("FAIL br_cnt got=%0d exp=2", stall_cnt); end
      idle();
   endtask

   task automatic test_mem_freeze();
      br_taken = 1'b1; dmem_busy = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #2;
         checks++; if ({pc_we, if_id_we, id_ex_we, ex_mem_we, f_ifid, f_idex} !== 6'b000000) begin
            failures++; $display("FAIL freeze_c%0d got=%b exp=000000", i, {pc_we, if_id_we, id_ex_we, ex_mem_we, f_ifid, f_idex}); end
         tick();
      end
      checks++; if (stall_cnt !== 16'd6) begin
         failures++; $display("FAIL freeze_cnt got=%0d exp=6", stall_cnt); end
      dmem_busy = 1'b0; #2;
      checks++; if ({pc_we, f_ifid, f_idex} !== 3'b111) begin
         failures++; $display("FAIL release_flush got=%b exp=111", {pc_we, f_ifid, f_idex}); end
      tick();
      br_taken = 1'b0; #2;
      checks++; if ({f_ifid, f_idex, stall_cnt} !== {2'b00, 16'd6}) begin
         failures++; $display("FAIL release_once got fl=%b cnt=%0d exp fl=00 cnt=6", {f_ifid, f_idex}, stall_cnt); end
   endtask

   task automatic test_halt_drain();
      ex_op = HLT; #2;
      checks++; if ({pc_we, if_id_we, ex_mem_we, f_idex} !== 4'b0011) begin
         failures++; $display("FAIL hlt_ex got=%b exp=0011", {pc_we, if_id_we, ex_mem_we, f_idex}); end
      tick();
      ex_op = 4'd0;
      for (int i = 1; i <= 3; i++) begin
         br_taken = 1'b1; #2;
         checks++; if ({halt, pc_we, if_id_we, ex_mem_we, f_ifid, f_idex} !== 6'b000101) begin
            failures++; $display("FAIL drain_c%0d got=%b exp=000101", i, {halt, pc_we, if_id_we, ex_mem_we, f_ifid, f_idex}); end
         tick();
      end
      checks++; if ({halt, stall_cnt} !== {1'b1, 16'd10}) begin
         failures++; $display("FAIL halt_set got halt=%b cnt=%0d exp halt=1 cnt=10", halt, stall_cnt); end
      tick(); tick();
      checks++; if ({halt, pc_we, if_id_we, id_ex_we, ex_mem_we, f_ifid, f_idex, stall_cnt} !== {7'b1000011, 16'd10}) begin
         failures++; $display("FAIL halted_hold got=%b cnt=%0d exp=1000011 cnt=10", {halt, pc_we, if_id_we, id_ex_we, ex_mem_we, f_ifid, f_idex}, stall_cnt); end
      idle(); rst = 1'b1; tick(); rst = 1'b0;
      checks++; if ({halt, stall_cnt} !== 17'd0) begin
         failures++; $display("FAIL halt_clear got halt=%b cnt=%0d exp halt=0 cnt=0", halt, stall_cnt); end
      ex_op = HLT; tick(); ex_op = 4'd0;
      tick();
      dmem_busy = 1'b1; #2;
      checks++; if ({ex_mem_we, f_idex} !== 2'b01) begin
         failures++; $display("FAIL drain_busy got=%b exp=01", {ex_mem_we, f_idex}); end
      tick(); tick();
      dmem_busy = 1'b0; tick();
      checks++; if (halt !== 1'b0) begin
         failures++; $display("FAIL busy_halt_early got=%b exp=0", halt); end
      tick();
      checks++; if ({halt, stall_cnt} !== {1'b1, 16'd6}) begin
         failures++; $display("FAIL busy_halt got halt=%b cnt=%0d exp halt=1 cnt=6", halt, stall_cnt); end
   endtask

   task automatic test_saturation_reset();
      idle(); rst = 1'b1; tick(); rst = 1'b0;
      dmem_busy = 1'b1;
      repeat (20) tick();
      checks++; if (s_stall_cnt !== 4'd15) begin
         failures++; $display("FAIL sat_cnt got=%0d exp=15", s_stall_cnt); end
      checks++; if (stall_cnt !== 16'd20) begin
         failures++; $display("FAIL wide_cnt got=%0d exp=20", stall_cnt); end
      dmem_busy = 1'b0; ex_op = HLT; tick();
      ex_op = 4'd0; tick();
      rst = 1'b1; #2;
      checks++; if ({pc_we, if_id_we, id_ex_we, ex_mem_we, f_ifid, f_idex} !== 6'b000011) begin
         failures++; $display("FAIL rst_drain_out got=%b exp=000011", {pc_we, if_id_we, id_ex_we, ex_mem_we, f_ifid, f_idex}); end
      tick();
      checks++; if ({halt, stall_cnt, s_halt, s_stall_cnt} !== 22'd0) begin
         failures++; $display("FAIL rst_drain_regs got halt=%b cnt=%0d scnt=%0d exp 0", halt, stall_cnt, s_stall_cnt); end
      rst = 1'b0; #2;
      checks++; if ({pc_we, if_id_we, id_ex_we, ex_mem_we, f_ifid, f_idex} !== 6'b111100) begin
         failures++; $display("FAIL rst_to_run got=%b exp=111100", {pc_we, if_id_we, id_ex_we, ex_mem_we, f_ifid, f_idex}); end
      tick();
      checks++; if (halt !== 1'b0) begin
         failures++; $display("FAIL run_no_halt got=%b exp=0", halt); end
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_masking();
      test_branch_vs_lu();
      test_mem_freeze();
      test_halt_drain();
      test_saturation_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
